// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_hazard_ctrl_pkg
// Brief  : Shared types and constants for the 5-stage MIPS hazard controller:
//          FSM state encoding, forwarding-select encoding, shadow-pipe entry
//          structs and the opcode constants shared with control_unit.
// Rev    : 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_t;

  // Opcodes shared with control_unit
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  // Shadow of the ID-EX register: what the hazard logic needs to know
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } ex_entry_t;

  // Shadow of EX-MEM / MEM-WB: only the write-back identity matters
  typedef struct packed {
    logic [4:0] dest;
    logic       reg_write;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipeline_hazard_ctrl_if
// Brief  : Bundle between the pipeline datapath/decoder (master) and the
//          hazard controller (slave).
//   master drives : id_rs, id_rt, id_uses_rt, id_dest, id_RegWrite,
//                   id_MemRead, id_jcond, ex_branch_taken, mem_busy
//   slave drives  : pc_write, ifid_write, ifid_flush, idex_bubble,
//                   fwd_a, fwd_b, stall_count, mem_timeout_err
// Rev    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       id_dest;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic             id_jcond;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout_err;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_dest, id_RegWrite, id_MemRead,
           id_jcond, ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           stall_count, mem_timeout_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_dest, id_RegWrite, id_MemRead,
           id_jcond, ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           stall_count, mem_timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module : fwd_select
// Brief  : Combinational forwarding select for one EX operand.
//   src           in  5  register number the EX operand reads
//   mem_dest      in  5  destination of the instruction in MEM
//   mem_reg_write in  1  MEM instruction writes the register file
//   wb_dest       in  5  destination of the instruction in WB
//   wb_reg_write  in  1  WB instruction writes the register file
//   sel           out 2  FWD_EXMEM / FWD_MEMWB / FWD_RF
// Rev    : 1.0  initial release
// ============================================================================
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_dest,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_dest,
  input  logic       wb_reg_write,
  output fwd_t       sel
);

  // MEM holds the younger result, so it wins over WB; $0 is hard-wired zero.
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_dest != 5'd0) && (mem_dest == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_reg_write && (wb_dest != 5'd0) && (wb_dest == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Hazard controller for the 5-stage MIPS pipeline. Keeps a shadow of
//          the EX/MEM/WB write-back identity, detects load-use hazards,
//          drives PC/IF-ID enables, IF-ID flush, ID-EX bubble and EX
//          forwarding selects, holds the pipe on data-memory wait states and
//          counts stall cycles.
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous active-high reset
//   bus    slave modport of pipeline_hazard_ctrl_if (decoder/pipe signals in,
//          enables/flush/bubble/forward selects/counters out)
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_ctrl_if.slave        bus
);

  localparam int               WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state, w_state_next;
  ex_entry_t         r_ex;
  wb_entry_t         r_mem, r_wb;
  logic [CNT_W-1:0]  r_stall_count;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_timeout_err;

  logic w_loaduse;
  logic w_pc_write, w_ifid_write, w_flush, w_bubble;
  fwd_t w_sel_a, w_sel_b;

  assign w_loaduse = r_ex.mem_read && (r_ex.dest != 5'd0) &&
                     ((r_ex.dest == bus.id_rs) ||
                      (bus.id_uses_rt && (r_ex.dest == bus.id_rt)));

  // Action priority: memory hold > taken branch > load-use > jump > run.
  // A jump colliding with a load-use is simply held in ID and seen again.
  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;
    if (reset) begin
      // defaults: the reset cycle presents RUN outputs
    end else if (bus.mem_busy) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
    end else if (bus.ex_branch_taken) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_loaduse) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_bubble     = 1'b1;
    end else if (bus.id_jcond) begin
      w_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN: begin
        if (bus.mem_busy) begin
          w_state_next = MEM_WAIT;
        end else if (!bus.ex_branch_taken && w_loaduse) begin
          w_state_next = LU_STALL;
        end
      end
      LU_STALL: w_state_next = bus.mem_busy ? MEM_WAIT : RUN;
      MEM_WAIT: if (!bus.mem_busy) w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase
  end

  fwd_select u_fwd_a (
    .src           (r_ex.rs),
    .mem_dest      (r_mem.dest),
    .mem_reg_write (r_mem.reg_write),
    .wb_dest       (r_wb.dest),
    .wb_reg_write  (r_wb.reg_write),
    .sel           (w_sel_a)
  );

  fwd_select u_fwd_b (
    .src           (r_ex.rt),
    .mem_dest      (r_mem.dest),
    .mem_reg_write (r_mem.reg_write),
    .wb_dest       (r_wb.dest),
    .wb_reg_write  (r_wb.reg_write),
    .sel           (w_sel_b)
  );

  // Counts consecutive busy cycles, including the one that enters MEM_WAIT,
  // so MEM_TIMEOUT busy cycles in a row raise the error. Saturates at max.
  assign w_wait_inc = r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb          <= '0;
      r_stall_count <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (!bus.mem_busy) begin
        r_wb  <= r_mem;
        r_mem <= '{dest: r_ex.dest, reg_write: r_ex.reg_write};
        if (w_bubble) begin
          r_ex <= '0;
        end else begin
          r_ex <= '{rs: bus.id_rs, rt: bus.id_rt, dest: bus.id_dest,
                    reg_write: bus.id_RegWrite, mem_read: bus.id_MemRead};
        end
      end

      if (!w_pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end

      if (bus.mem_busy) begin
        if (r_wait_cnt != c_wait_max) r_wait_cnt <= w_wait_inc;
        if (w_wait_inc >= c_wait_max) r_timeout_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.pc_write        = w_pc_write;
  assign bus.ifid_write      = w_ifid_write;
  assign bus.ifid_flush      = w_flush;
  assign bus.idex_bubble     = w_bubble;
  assign bus.fwd_a           = reset ? FWD_RF : w_sel_a;
  assign bus.fwd_b           = reset ? FWD_RF : w_sel_b;
  assign bus.stall_count     = r_stall_count;
  assign bus.mem_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipeline_hazard_ctrl
// Brief  : Scoreboard bench for pipeline_hazard_ctrl. A stimulus process
//          drives directed and random pipeline traffic and pushes the
//          reference outputs; a monitor pops and compares every cycle.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int CNT_W       = 4;   // narrow so saturation is reached
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic             pc;
    logic             ifid;
    logic             flush;
    logic             bubble;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the three older instructions in flight plus counters.
  // stage index 0 = EX, 1 = MEM, 2 = WB
  int m_dest [3];
  int m_rw   [3];
  int m_ex_rs, m_ex_rt, m_ex_mr;
  int m_cnt, m_busy_run, m_err;

  function automatic logic [1:0] ref_fwd(input int src);
    if (m_rw[1] != 0 && m_dest[1] != 0 && m_dest[1] == src) return 2'b10;
    if (m_rw[2] != 0 && m_dest[2] != 0 && m_dest[2] == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_dest[i] = 0;
      m_rw[i]   = 0;
    end
    m_ex_rs = 0; m_ex_rt = 0; m_ex_mr = 0;
    m_cnt = 0; m_busy_run = 0; m_err = 0;
  endtask

  task automatic drive(input bit rst, input int rs, input int rt, input bit urt,
                       input int dest, input bit rw, input bit mr, input bit j,
                       input bit br, input bit busy);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.id_rs           = 5'(rs);
    bus.id_rt           = 5'(rt);
    bus.id_uses_rt      = urt;
    bus.id_dest         = 5'(dest);
    bus.id_RegWrite     = rw;
    bus.id_MemRead      = mr;
    bus.id_jcond        = j;
    bus.ex_branch_taken = br;
    bus.mem_busy        = busy;

    lu = (m_ex_mr != 0) && (m_dest[0] != 0) &&
         (m_dest[0] == rs || (urt && m_dest[0] == rt));
    e.pc = 1; e.ifid = 1; e.flush = 0; e.bubble = 0;
    if (rst) begin
    end else if (busy) begin
      e.pc = 0; e.ifid = 0;
    end else if (br) begin
      e.flush = 1; e.bubble = 1;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.bubble = 1;
    end else if (j) begin
      e.flush = 1;
    end
    e.fa  = rst ? 2'b00 : ref_fwd(m_ex_rs);
    e.fb  = rst ? 2'b00 : ref_fwd(m_ex_rt);
    e.cnt = CNT_W'(m_cnt);
    e.err = (m_err != 0);
    q.push_back(e);

    // state after the coming rising edge
    if (rst) begin
      model_clear();
    end else begin
      if (!e.pc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (busy) begin
        m_busy_run++;
        if (m_busy_run >= MEM_TIMEOUT) m_err = 1;
      end else begin
        m_busy_run = 0;
        m_dest[2] = m_dest[1]; m_rw[2] = m_rw[1];
        m_dest[1] = m_dest[0]; m_rw[1] = m_rw[0];
        if (e.bubble) begin
          m_dest[0] = 0; m_rw[0] = 0; m_ex_rs = 0; m_ex_rt = 0; m_ex_mr = 0;
        end else begin
          m_dest[0] = dest; m_rw[0] = rw; m_ex_rs = rs; m_ex_rt = rt; m_ex_mr = mr;
        end
      end
    end
  endtask

  task automatic nop(input bit busy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_write",        16'(bus.pc_write),        16'(e.pc));
        chk("ifid_write",      16'(bus.ifid_write),      16'(e.ifid));
        chk("ifid_flush",      16'(bus.ifid_flush),      16'(e.flush));
        chk("idex_bubble",     16'(bus.idex_bubble),     16'(e.bubble));
        chk("fwd_a",           16'(bus.fwd_a),           16'(e.fa));
        chk("fwd_b",           16'(bus.fwd_b),           16'(e.fb));
        chk("stall_count",     16'(bus.stall_count),     16'(e.cnt));
        chk("mem_timeout_err", 16'(bus.mem_timeout_err), 16'(e.err));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.id_dest = '0;
    bus.id_RegWrite = 1'b0; bus.id_MemRead = 1'b0; bus.id_jcond = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0;
    model_clear();

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // load-use: LW $2, then consumer reading $2
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    drive(0, 2, 5, 1, 4, 1, 0, 0, 0, 0);
    drive(0, 2, 5, 1, 4, 1, 0, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // MEM and WB both write $3; then MEM writes $0 instead
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    drive(0, 3, 3, 1, 7, 1, 0, 0, 0, 0);
    nop(0);
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 3, 3, 1, 7, 1, 0, 0, 0, 0);
    nop(0); nop(0);

    // taken branch together with load-use and jump
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    drive(0, 2, 2, 1, 0, 0, 0, 1, 1, 0);
    nop(0);

    // load-use with three memory-busy cycles
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 2, 0, 0, 4, 1, 0, 0, 0, 1);
    drive(0, 2, 0, 0, 4, 1, 0, 0, 0, 0);
    drive(0, 2, 0, 0, 4, 1, 0, 0, 0, 0);
    nop(0);

    // reset while in the load-use stall
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    drive(0, 2, 0, 0, 4, 1, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 4, 1, 0, 0, 0, 0);
    nop(0); nop(0);

    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 63) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0));
    end

    // timeout: 15 busy cycles do not trip it, 16 in a row do
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) nop(1);
    nop(0); nop(0);
    for (int i = 0; i < 17; i++) nop(1);
    nop(0); nop(0); nop(0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0); nop(0);

    // let the monitor drain, with a bound
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
